// File: rtl/regfile_wb_sink.sv
// regfile_wb_sink
//   32-entry general purpose register file of the MIPS32 pipeline. It takes
//   the writeback stream, serves two registered read ports to the ID stage
//   (with same-edge WB->read bypass), keeps a per-register busy scoreboard of
//   pending writers and derives the ID-stage stall flag from it.
//
// Ports
//   clk          pipeline clock, all state updates on posedge
//   rst          asynchronous, active-high reset
//   WB_RegWrite  writeback strobe
//   WB_rd        writeback destination register
//   WB_data      writeback data
//   HALTED       halt indication from WB (captured sticky into halted_q)
//   rd_en        ID read strobe; rs_data/rt_data hold when low
//   rs_addr      read port A address
//   rt_addr      read port B address
//   rs_data      registered read data A (1-cycle latency)
//   rt_data      registered read data B (1-cycle latency)
//   iss_valid    ID issues an instruction that will write iss_rd
//   iss_rd       destination of the issued instruction
//   rs_busy      combinational busy bit of rs_addr
//   rt_busy      combinational busy bit of rt_addr
//   stall        combinational rd_en & (rs_busy | rt_busy)
//   halted_q     sticky registered copy of HALTED
//
// Handshake: there is no back-pressure. iss_valid and WB_RegWrite are plain
// one-cycle strobes sampled on the posedge; the ID stage itself must honour
// stall by not advancing while it is high.

module regfile_wb_sink #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_RegWrite,
  input  logic [4:0]        WB_rd,
  input  logic [DATA_W-1:0] WB_data,
  input  logic              HALTED,
  input  logic              rd_en,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              stall,
  output logic              halted_q
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;
  logic              wr_qual;
  logic              iss_set;
  logic [DATA_W-1:0] rs_next;
  logic [DATA_W-1:0] rt_next;

  // A write only counts when not halted and not aimed at R0. Because R0 is
  // excluded here, the bypass below can never forward into R0 either.
  assign wr_qual = WB_RegWrite && !halted_q && (WB_rd != 5'd0);
  assign iss_set = iss_valid && (iss_rd != 5'd0);

  // Register array. R0 is never written, so it stays at its reset value 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_qual) begin
      regs[WB_rd] <= WB_data;
    end
  end

  // Read with same-edge bypass from the qualifying writeback.
  always_comb begin
    rs_next = regs[rs_addr];
    rt_next = regs[rt_addr];
    if (wr_qual && (WB_rd == rs_addr)) rs_next = WB_data;
    if (wr_qual && (WB_rd == rt_addr)) rt_next = WB_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data <= '0;
      rt_data <= '0;
    end else if (rd_en) begin
      rs_data <= rs_next;
      rt_data <= rt_next;
    end
  end

  // Scoreboard: the clear is applied before the set so that a new writer
  // issued on the same edge as the WB of an older one stays pending.
  always_comb begin
    busy_next = busy;
    if (wr_qual) busy_next[WB_rd] = 1'b0;
    if (iss_set) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (!halted_q) begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (HALTED) begin
      halted_q <= 1'b1;
    end
  end

  // Hazard flags look only at the current busy vector; a WB clearing the
  // bit on this edge is covered by the bypass path, not by these flags.
  assign rs_busy = busy[rs_addr];
  assign rt_busy = busy[rt_addr];
  assign stall   = rd_en && (rs_busy || rt_busy);

endmodule
